// File: rtl/buffer_ctrl.sv
// -----------------------------------------------------------------------------
// buffer_ctrl
//
// Sequencing and access controller for the 64-byte endpoint data buffer.
// Arbitrates between the USB RX protocol engine (byte writes), the USB TX
// protocol engine (byte reads) and the AHB host slave (1/2/4-byte writes and
// reads). Drives the buffer's store/get/clear strobes and enforces packet
// direction, capacity and occupancy rules.
//
// Ports:
//   clk, rst               system clock; synchronous active-high reset
//   buffer_occ[6:0]        byte occupancy reported by the data buffer
//   rx_byte_valid          RX engine presents one data byte
//   rx_packet_done         RX packet ended with good CRC
//   rx_packet_err          RX packet aborted
//   tx_byte_req            TX engine requests the next byte
//   tx_packet_done         TX engine finished sending the packet
//   host_wr_req/size[1:0]  host write request (size 0=invalid,1=1B,2=2B,3=4B)
//   host_rd_req/size[1:0]  host read request, same size encoding
//   host_start_tx          host commands transmission of buffered data
//   host_clear             host flush command
//   store_rx_packet_data   strobe: write one RX byte into the buffer
//   get_tx_packet_data     strobe: read one TX byte from the buffer
//   store_tx_data[1:0]     strobe: host write, size encoded
//   get_rx_data[1:0]       strobe: host read, size encoded
//   clear                  buffer clear pulse
//   host_wr_ack/err        host write accepted / rejected this cycle
//   host_rd_ack/err        host read accepted / rejected this cycle
//   rx_data_ready          level: a completed RX packet is waiting
//   rx_packet_len[6:0]     byte count of the last completed RX packet
//   tx_active              level: buffer owned by the TX engine
//   rx_drop                pulse: an RX byte was discarded
//
// All strobes, acks, errors, clear and rx_drop are combinational from the
// inputs and the registered state; state, byte counter and rx_packet_len are
// registered. Only the registered buffer_occ is used for capacity decisions.
// -----------------------------------------------------------------------------
module buffer_ctrl #(
  parameter int CAPACITY = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] buffer_occ,
  input  logic       rx_byte_valid,
  input  logic       rx_packet_done,
  input  logic       rx_packet_err,
  input  logic       tx_byte_req,
  input  logic       tx_packet_done,
  input  logic       host_wr_req,
  input  logic [1:0] host_wr_size,
  input  logic       host_rd_req,
  input  logic [1:0] host_rd_size,
  input  logic       host_start_tx,
  input  logic       host_clear,
  output logic       store_rx_packet_data,
  output logic       get_tx_packet_data,
  output logic [1:0] store_tx_data,
  output logic [1:0] get_rx_data,
  output logic       clear,
  output logic       host_wr_ack,
  output logic       host_rd_ack,
  output logic       host_wr_err,
  output logic       host_rd_err,
  output logic       rx_data_ready,
  output logic [6:0] rx_packet_len,
  output logic       tx_active,
  output logic       rx_drop
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_FILL  = 3'd1,
    RX_READY = 3'd2,
    TX_FILL  = 3'd3,
    TX_SEND  = 3'd4
  } state_t;

  localparam logic [7:0] CAP8 = 8'(CAPACITY);

  state_t     state_reg, state_next;
  logic [6:0] count_reg, count_next;
  logic [6:0] len_reg, len_next;

  // Size code to byte count: 0 -> 0, 1 -> 1, 2 -> 2, 3 -> 4.
  function automatic logic [7:0] size_bytes(input logic [1:0] size);
    logic [7:0] n;
    case (size)
      2'd1:    n = 8'd1;
      2'd2:    n = 8'd2;
      2'd3:    n = 8'd4;
      default: n = 8'd0;
    endcase
    return n;
  endfunction

  // Capacity arithmetic is done on 8 bits so occ + 4 can never wrap.
  logic [7:0] occ8;
  logic       occ_full;
  logic       occ_empty;
  logic       wr_fits;
  logic       rd_fits;

  assign occ8      = {1'b0, buffer_occ};
  assign occ_full  = (occ8 >= CAP8);
  assign occ_empty = (buffer_occ == 7'd0);
  assign wr_fits   = (host_wr_size != 2'd0) &&
                     ((occ8 + size_bytes(host_wr_size)) <= CAP8);
  assign rd_fits   = (host_rd_size != 2'd0) &&
                     (size_bytes(host_rd_size) <= occ8);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= 7'd0;
      len_reg   <= 7'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      len_reg   <= len_next;
    end
  end

  assign rx_packet_len = len_reg;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next           = state_reg;
    count_next           = count_reg;
    len_next             = len_reg;
    store_rx_packet_data = 1'b0;
    get_tx_packet_data   = 1'b0;
    store_tx_data        = 2'd0;
    get_rx_data          = 2'd0;
    clear                = 1'b0;
    host_wr_ack          = 1'b0;
    host_rd_ack          = 1'b0;
    host_wr_err          = 1'b0;
    host_rd_err          = 1'b0;
    rx_data_ready        = 1'b0;
    tx_active            = 1'b0;
    rx_drop              = 1'b0;

    // While rst is high every output stays quiet; the register block
    // overrides the next state, so nothing here leaks into state either.
    if (!rst) begin
      // Levels derive from the registered state only.
      rx_data_ready = (state_reg == RX_READY);
      tx_active     = (state_reg == TX_SEND);

      if (host_clear) begin
        // Flush wins over every other event in every state.
        clear      = 1'b1;
        state_next = IDLE;
        count_next = 7'd0;
        len_next   = 7'd0;
      end else begin
        case (state_reg)
          IDLE: begin
            count_next  = 7'd0;
            host_rd_err = host_rd_req;
            if (rx_byte_valid) begin
              // RX wins a same-cycle race; a pending host write is neither
              // acked nor rejected and will be refused once in RX_FILL.
              store_rx_packet_data = 1'b1;
              count_next           = 7'd1;
              state_next           = RX_FILL;
            end else begin
              if (host_wr_req) begin
                if (host_wr_size != 2'd0) begin
                  host_wr_ack   = 1'b1;
                  store_tx_data = host_wr_size;
                  state_next    = TX_FILL;
                end else begin
                  host_wr_err = 1'b1;
                end
              end
              // A start in the same cycle as a write takes the written
              // data straight into transmission.
              if (host_start_tx) begin
                state_next = TX_SEND;
              end
            end
          end

          RX_FILL: begin
            if (rx_packet_err) begin
              clear      = 1'b1;
              state_next = IDLE;
              count_next = 7'd0;
            end else begin
              host_wr_err = host_wr_req;
              host_rd_err = host_rd_req;
              if (rx_byte_valid) begin
                if (!occ_full) begin
                  store_rx_packet_data = 1'b1;
                  count_next           = count_reg + 7'd1;
                end else begin
                  // Overflow discards the whole packet.
                  rx_drop    = 1'b1;
                  clear      = 1'b1;
                  state_next = IDLE;
                  count_next = 7'd0;
                end
              end
              // A byte arriving with the done flag is counted; an
              // overflow on that cycle cancels the completion.
              if (rx_packet_done && !(rx_byte_valid && occ_full)) begin
                len_next   = count_next;
                state_next = RX_READY;
              end
            end
          end

          RX_READY: begin
            host_wr_err = host_wr_req;
            rx_drop     = rx_byte_valid;
            if (host_rd_req) begin
              if (rd_fits) begin
                host_rd_ack = 1'b1;
                get_rx_data = host_rd_size;
              end else begin
                host_rd_err = 1'b1;
              end
            end
            // Release the buffer once the host has drained it.
            if (occ_empty && !host_rd_ack) begin
              state_next = IDLE;
            end
          end

          TX_FILL: begin
            host_rd_err = host_rd_req;
            rx_drop     = rx_byte_valid;
            if (host_wr_req) begin
              if (wr_fits) begin
                host_wr_ack   = 1'b1;
                store_tx_data = host_wr_size;
              end else begin
                host_wr_err = 1'b1;
              end
            end
            if (host_start_tx) begin
              state_next = TX_SEND;
            end
          end

          TX_SEND: begin
            host_wr_err = host_wr_req;
            host_rd_err = host_rd_req;
            rx_drop     = rx_byte_valid;
            if (tx_packet_done) begin
              // End of packet takes precedence over a last byte request so
              // clear and get never coincide.
              clear      = 1'b1;
              state_next = IDLE;
            end else if (tx_byte_req && !occ_empty) begin
              get_tx_packet_data = 1'b1;
            end
          end

          default: begin
            state_next = IDLE;
            count_next = 7'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_buffer_ctrl
//
// Directed bench for buffer_ctrl. A small behavioural data buffer supplies
// buffer_occ from the controller's strobes (one cycle later, as the real
// buffer does). All DUT outputs except rx_packet_len are packed into one
// vector so each cycle is compared against a hand-built expected pattern.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] buffer_occ;
  logic       rx_byte_valid, rx_packet_done, rx_packet_err;
  logic       tx_byte_req, tx_packet_done;
  logic       host_wr_req, host_rd_req, host_start_tx, host_clear;
  logic [1:0] host_wr_size, host_rd_size;
  logic       store_rx_packet_data, get_tx_packet_data, clear;
  logic [1:0] store_tx_data, get_rx_data;
  logic       host_wr_ack, host_rd_ack, host_wr_err, host_rd_err;
  logic       rx_data_ready, tx_active, rx_drop;
  logic [6:0] rx_packet_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buffer_ctrl #(.CAPACITY(64)) dut (
    .clk(clk), .rst(rst), .buffer_occ(buffer_occ),
    .rx_byte_valid(rx_byte_valid), .rx_packet_done(rx_packet_done),
    .rx_packet_err(rx_packet_err), .tx_byte_req(tx_byte_req),
    .tx_packet_done(tx_packet_done), .host_wr_req(host_wr_req),
    .host_wr_size(host_wr_size), .host_rd_req(host_rd_req),
    .host_rd_size(host_rd_size), .host_start_tx(host_start_tx),
    .host_clear(host_clear), .store_rx_packet_data(store_rx_packet_data),
    .get_tx_packet_data(get_tx_packet_data), .store_tx_data(store_tx_data),
    .get_rx_data(get_rx_data), .clear(clear), .host_wr_ack(host_wr_ack),
    .host_rd_ack(host_rd_ack), .host_wr_err(host_wr_err),
    .host_rd_err(host_rd_err), .rx_data_ready(rx_data_ready),
    .rx_packet_len(rx_packet_len), .tx_active(tx_active), .rx_drop(rx_drop)
  );

  // Output vector layout and single-bit patterns.
  logic [13:0] outs;
  assign outs = {store_rx_packet_data, get_tx_packet_data, store_tx_data,
                 get_rx_data, clear, host_wr_ack, host_rd_ack, host_wr_err,
                 host_rd_err, rx_data_ready, tx_active, rx_drop};

  localparam logic [13:0] O_NONE     = 14'h0000;
  localparam logic [13:0] O_STORE_RX = 14'h2000;
  localparam logic [13:0] O_GET_TX   = 14'h1000;
  localparam logic [13:0] O_STX1     = 14'h0400;
  localparam logic [13:0] O_STX2     = 14'h0800;
  localparam logic [13:0] O_STX4     = 14'h0C00;
  localparam logic [13:0] O_GRX1     = 14'h0100;
  localparam logic [13:0] O_GRX4     = 14'h0300;
  localparam logic [13:0] O_CLEAR    = 14'h0080;
  localparam logic [13:0] O_WR_ACK   = 14'h0040;
  localparam logic [13:0] O_RD_ACK   = 14'h0020;
  localparam logic [13:0] O_WR_ERR   = 14'h0010;
  localparam logic [13:0] O_RD_ERR   = 14'h0008;
  localparam logic [13:0] O_RDY      = 14'h0004;
  localparam logic [13:0] O_TXA      = 14'h0002;
  localparam logic [13:0] O_DROP     = 14'h0001;

  // Behavioural data buffer: occupancy follows the strobes one cycle later.
  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'd1:    return 1;
      2'd2:    return 2;
      2'd3:    return 4;
      default: return 0;
    endcase
  endfunction

  int occ_n;
  always @(posedge clk) begin
    if (rst || clear) begin
      buffer_occ <= 7'd0;
    end else begin
      occ_n = int'(buffer_occ) + int'(store_rx_packet_data) + nbytes(store_tx_data)
              - int'(get_tx_packet_data) - nbytes(get_rx_data);
      buffer_occ <= occ_n[6:0];
    end
  end

  task automatic idle_inputs();
    rx_byte_valid = 0; rx_packet_done = 0; rx_packet_err = 0;
    tx_byte_req = 0; tx_packet_done = 0;
    host_wr_req = 0; host_wr_size = 0; host_rd_req = 0; host_rd_size = 0;
    host_start_tx = 0; host_clear = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    @(negedge clk); rx_byte_valid = 1; host_rd_req = 1; host_rd_size = 1; #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL reset_quiet: outs=%b expected=%b", outs, O_NONE);
    end
    @(negedge clk); idle_inputs(); rst = 0; #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL reset_outs: outs=%b expected=%b", outs, O_NONE);
    end
    checks++;
    if (rx_packet_len !== 7'd0) begin
      errors++; $display("FAIL reset_len: len=%0d expected=0", rx_packet_len);
    end
    $display("test_reset done");
  endtask

  task automatic test_rx_read();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); rx_byte_valid = 1; #1;
      checks++;
      if (outs !== O_STORE_RX) begin
        errors++; $display("FAIL rx_store byte %0d: outs=%b expected=%b", i, outs, O_STORE_RX);
      end
    end
    @(negedge clk); rx_byte_valid = 0; rx_packet_done = 1; #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL rx_done: outs=%b expected=%b", outs, O_NONE);
    end
    @(negedge clk); rx_packet_done = 0; #1;
    checks++;
    if (outs !== O_RDY) begin
      errors++; $display("FAIL rx_ready: outs=%b expected=%b", outs, O_RDY);
    end
    checks++;
    if (rx_packet_len !== 7'd5) begin
      errors++; $display("FAIL rx_len: len=%0d expected=5", rx_packet_len);
    end
    // occ 5: read 4 bytes (size 3) -> occ 1
    @(negedge clk); host_rd_req = 1; host_rd_size = 3; #1;
    checks++;
    if (outs !== (O_RDY | O_RD_ACK | O_GRX4)) begin
      errors++; $display("FAIL rd_size3: outs=%b expected=%b", outs, O_RDY | O_RD_ACK | O_GRX4);
    end
    @(negedge clk); host_rd_req = 0; #1;
    // occ 1: size 2 exceeds occupancy
    @(negedge clk); host_rd_req = 1; host_rd_size = 2; #1;
    checks++;
    if (outs !== (O_RDY | O_RD_ERR)) begin
      errors++; $display("FAIL rd_size2_occ1: outs=%b expected=%b", outs, O_RDY | O_RD_ERR);
    end
    @(negedge clk); host_rd_req = 0; #1;
    // size 0 is always rejected
    @(negedge clk); host_rd_req = 1; host_rd_size = 0; #1;
    checks++;
    if (outs !== (O_RDY | O_RD_ERR)) begin
      errors++; $display("FAIL rd_size0: outs=%b expected=%b", outs, O_RDY | O_RD_ERR);
    end
    @(negedge clk); host_rd_req = 0; #1;
    @(negedge clk); host_rd_req = 1; host_rd_size = 1; #1;
    checks++;
    if (outs !== (O_RDY | O_RD_ACK | O_GRX1)) begin
      errors++; $display("FAIL rd_size1: outs=%b expected=%b", outs, O_RDY | O_RD_ACK | O_GRX1);
    end
    // occ now 0 -> still RX_READY this cycle, IDLE the next
    @(negedge clk); host_rd_req = 0; #1;
    checks++;
    if (outs !== O_RDY) begin
      errors++; $display("FAIL rx_drained: outs=%b expected=%b", outs, O_RDY);
    end
    @(negedge clk); #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL rx_to_idle: outs=%b expected=%b", outs, O_NONE);
    end
    // An accepted host write proves IDLE.
    @(negedge clk); host_wr_req = 1; host_wr_size = 1; #1;
    checks++;
    if (outs !== (O_WR_ACK | O_STX1)) begin
      errors++; $display("FAIL rx_idle_probe: outs=%b expected=%b", outs, O_WR_ACK | O_STX1);
    end
    @(negedge clk); host_wr_req = 0; host_clear = 1; #1;
    checks++;
    if (outs !== O_CLEAR) begin
      errors++; $display("FAIL host_clear_txfill: outs=%b expected=%b", outs, O_CLEAR);
    end
    @(negedge clk); host_clear = 0; #1;
    checks++;
    if (rx_packet_len !== 7'd0) begin
      errors++; $display("FAIL clear_len: len=%0d expected=0", rx_packet_len);
    end
    $display("test_rx_read done");
  endtask

  task automatic test_rx_overflow();
    for (int i = 1; i <= 65; i++) begin
      @(negedge clk); rx_byte_valid = 1; #1;
      checks++;
      if (i <= 64 && outs !== O_STORE_RX) begin
        errors++; $display("FAIL ovf_store byte %0d: outs=%b expected=%b", i, outs, O_STORE_RX);
      end else if (i == 65 && outs !== (O_DROP | O_CLEAR)) begin
        errors++; $display("FAIL ovf_drop byte 65: outs=%b expected=%b", outs, O_DROP | O_CLEAR);
      end
    end
    @(negedge clk); rx_byte_valid = 0; host_wr_req = 1; host_wr_size = 2; #1;
    checks++;
    if (outs !== (O_WR_ACK | O_STX2)) begin
      errors++; $display("FAIL ovf_idle_probe: outs=%b expected=%b", outs, O_WR_ACK | O_STX2);
    end
    @(negedge clk); host_wr_req = 0; host_clear = 1; #1;
    @(negedge clk); host_clear = 0; #1;
    $display("test_rx_overflow done");
  endtask

  task automatic test_tx_capacity();
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk); host_wr_req = 1; host_wr_size = 3; #1;
      checks++;
      if (i <= 16 && outs !== (O_WR_ACK | O_STX4)) begin
        errors++; $display("FAIL tx_wr %0d: outs=%b expected=%b", i, outs, O_WR_ACK | O_STX4);
      end else if (i == 17 && outs !== O_WR_ERR) begin
        errors++; $display("FAIL tx_wr_full: outs=%b expected=%b", outs, O_WR_ERR);
      end
      @(negedge clk); host_wr_req = 0; #1;
    end
    @(negedge clk); host_wr_req = 1; host_wr_size = 1; #1;
    checks++;
    if (outs !== O_WR_ERR) begin
      errors++; $display("FAIL tx_wr1_full: outs=%b expected=%b", outs, O_WR_ERR);
    end
    @(negedge clk); host_wr_req = 0; host_rd_req = 1; host_rd_size = 1; rx_byte_valid = 1; #1;
    checks++;
    if (outs !== (O_RD_ERR | O_DROP)) begin
      errors++; $display("FAIL txfill_rd_rx: outs=%b expected=%b", outs, O_RD_ERR | O_DROP);
    end
    @(negedge clk); host_rd_req = 0; rx_byte_valid = 0; host_start_tx = 1; #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL tx_start: outs=%b expected=%b", outs, O_NONE);
    end
    @(negedge clk); host_start_tx = 0; #1;
    checks++;
    if (outs !== O_TXA) begin
      errors++; $display("FAIL tx_active: outs=%b expected=%b", outs, O_TXA);
    end
    for (int i = 1; i <= 65; i++) begin
      @(negedge clk); tx_byte_req = 1; #1;
      checks++;
      if (i <= 64 && outs !== (O_TXA | O_GET_TX)) begin
        errors++; $display("FAIL tx_get %0d: outs=%b expected=%b", i, outs, O_TXA | O_GET_TX);
      end else if (i == 65 && outs !== O_TXA) begin
        errors++; $display("FAIL tx_get_empty: outs=%b expected=%b", outs, O_TXA);
      end
    end
    @(negedge clk); tx_byte_req = 0; tx_packet_done = 1; #1;
    checks++;
    if (outs !== (O_TXA | O_CLEAR)) begin
      errors++; $display("FAIL tx_done: outs=%b expected=%b", outs, O_TXA | O_CLEAR);
    end
    @(negedge clk); tx_packet_done = 0; #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL tx_to_idle: outs=%b expected=%b", outs, O_NONE);
    end
    $display("test_tx_capacity done");
  endtask

  task automatic test_simultaneous();
    @(negedge clk); rx_byte_valid = 1; host_wr_req = 1; host_wr_size = 1; #1;
    checks++;
    if (outs !== O_STORE_RX) begin
      errors++; $display("FAIL simul_rx_wins: outs=%b expected=%b", outs, O_STORE_RX);
    end
    @(negedge clk); rx_byte_valid = 0; #1;
    checks++;
    if (outs !== O_WR_ERR) begin
      errors++; $display("FAIL simul_wr_err: outs=%b expected=%b", outs, O_WR_ERR);
    end
    @(negedge clk); host_wr_req = 0; host_clear = 1; #1;
    @(negedge clk); host_clear = 0; #1;
    $display("test_simultaneous done");
  endtask

  task automatic test_abort();
    // rx_packet_err mid-packet
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rx_byte_valid = 1; #1;
    end
    @(negedge clk); rx_byte_valid = 0; rx_packet_err = 1; #1;
    checks++;
    if (outs !== O_CLEAR) begin
      errors++; $display("FAIL abort_rx_err: outs=%b expected=%b", outs, O_CLEAR);
    end
    @(negedge clk); rx_packet_err = 0; host_wr_req = 1; host_wr_size = 1; #1;
    checks++;
    if (outs !== (O_WR_ACK | O_STX1)) begin
      errors++; $display("FAIL abort_idle_probe: outs=%b expected=%b", outs, O_WR_ACK | O_STX1);
    end
    @(negedge clk); host_wr_req = 0; host_clear = 1; #1;
    @(negedge clk); host_clear = 0; host_start_tx = 1; #1;
    // host_clear in TX_SEND
    @(negedge clk); host_start_tx = 0; host_clear = 1; #1;
    checks++;
    if (outs !== (O_TXA | O_CLEAR)) begin
      errors++; $display("FAIL abort_clear_txsend: outs=%b expected=%b", outs, O_TXA | O_CLEAR);
    end
    @(negedge clk); host_clear = 0; #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL abort_clear_idle: outs=%b expected=%b", outs, O_NONE);
    end
    // rst during RX_FILL: no clear, everything quiet afterwards
    @(negedge clk); rx_byte_valid = 1; #1;
    @(negedge clk); #1;
    @(negedge clk); rx_byte_valid = 0; rst = 1; #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL abort_rst_cycle: outs=%b expected=%b", outs, O_NONE);
    end
    @(negedge clk); rst = 0; #1;
    checks++;
    if (outs !== O_NONE || rx_packet_len !== 7'd0) begin
      errors++; $display("FAIL abort_rst_after: outs=%b len=%0d expected=%b len 0", outs, rx_packet_len, O_NONE);
    end
    @(negedge clk); host_wr_req = 1; host_wr_size = 1; #1;
    checks++;
    if (outs !== (O_WR_ACK | O_STX1)) begin
      errors++; $display("FAIL abort_rst_idle: outs=%b expected=%b", outs, O_WR_ACK | O_STX1);
    end
    @(negedge clk); host_wr_req = 0; host_clear = 1; #1;
    @(negedge clk); host_clear = 0; #1;
    $display("test_abort done");
  endtask

  task automatic test_zero_tx();
    @(negedge clk); host_start_tx = 1; #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL ztx_start: outs=%b expected=%b", outs, O_NONE);
    end
    @(negedge clk); host_start_tx = 0; tx_byte_req = 1; #1;
    checks++;
    if (outs !== O_TXA) begin
      errors++; $display("FAIL ztx_no_get: outs=%b expected=%b", outs, O_TXA);
    end
    @(negedge clk); tx_byte_req = 0; tx_packet_done = 1; #1;
    checks++;
    if (outs !== (O_TXA | O_CLEAR)) begin
      errors++; $display("FAIL ztx_done: outs=%b expected=%b", outs, O_TXA | O_CLEAR);
    end
    @(negedge clk); tx_packet_done = 0; #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL ztx_idle: outs=%b expected=%b", outs, O_NONE);
    end
    $display("test_zero_tx done");
  endtask

  initial begin
    buffer_occ = 7'd0;
    test_reset();
    test_rx_read();
    test_rx_overflow();
    test_tx_capacity();
    test_simultaneous();
    test_abort();
    test_zero_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
